// File: rtl/ifetch_queue.sv
// Instruction fetch queue: prefetches sequential words from imem into a DEPTH-entry FIFO; optional IFQ_BYPASS_EN macro.
// Latency: one cycle fetch-to-inst_valid by default; zero cycles through the empty-queue bypass when IFQ_BYPASS_EN is defined.
// Backpressure: inst_ready=0 lets the queue fill; once full, fetch_pc holds and imem_addr is stable until a pop.
module ifetch_queue #(
  parameter int             N        = 64,
  parameter int             DEPTH    = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [N-1:0]                 imem_addr,
  input  logic [31:0]                  imem_data,
  input  logic                         redirect,
  input  logic [N-1:0]                 redirect_pc,
  output logic [31:0]                  inst,
  output logic [N-1:0]                 inst_pc,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   inst_q [DEPTH];
  logic [N-1:0]  pc_q   [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  fetch_pc_q, fetch_pc_d;

  logic q_nonempty;
  logic q_pop;
  logic q_push;
  logic byp_take;

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;

  // Head presentation, handshake decode and push decision.
  always_comb begin
    q_nonempty = (count_q != '0);
    q_pop      = q_nonempty & inst_ready;
    byp_take   = 1'b0;
`ifdef IFQ_BYPASS_EN
    // Empty queue: the word arriving from imem is offered directly; taken words never occupy an entry.
    byp_take   = ~q_nonempty & ~redirect & ~reset & inst_ready;
    inst_valid = q_nonempty | (~redirect & ~reset);
    inst       = q_nonempty ? inst_q[head_q] : imem_data;
    inst_pc    = q_nonempty ? pc_q[head_q]   : fetch_pc_q;
`else
    inst_valid = q_nonempty;
    inst       = inst_q[head_q];
    inst_pc    = pc_q[head_q];
`endif
    // A full queue may still accept a word when the head leaves on the same edge.
    q_push = ~redirect & ~byp_take & ((count_q < CW'(DEPTH)) | q_pop);
  end

  // Next-state for pointers, occupancy and fetch address; redirect flushes everything.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (q_pop)  head_d = head_q + PW'(1);
      if (q_push) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(q_push) - CW'(q_pop);
      if (q_push | byp_take) fetch_pc_d = fetch_pc_q + N'(4);
    end
  end

  // Control state registers with synchronous reset that overrides redirect and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Entry storage; contents beyond count are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (q_push && !reset) begin
      inst_q[tail_q] <= imem_data;
      pc_q[tail_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter N, default 64, address/PC width.
REQ-002 Parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 imem_addr  output  N  byte address presented to instruction memory (imem indexes bits [7:2]).
REQ-007 imem_data  input  32  combinational instruction memory read data for imem_addr.
REQ-008 redirect  input  1  taken branch/flush request.
REQ-009 redirect_pc  input  N  new fetch address, sampled when redirect=1.
REQ-010 inst  output  32  head instruction toward IF/ID register.
REQ-011 inst_pc  output  N  byte address of inst.
REQ-012 inst_valid  output  1  inst/inst_pc hold a valid entry.
REQ-013 inst_ready  input  1  consumer accepts (IF/ID write enable; 0 during hazard stall).
REQ-014 count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-015 imem_addr SHALL equal fetch_pc register at all times.
REQ-016 Push: when redirect=0 and (count<DEPTH or a pop occurs this cycle), {imem_data, fetch_pc} SHALL be written at tail and fetch_pc SHALL advance by 4, modulo 2^N.
REQ-017 Pop: inst_valid & inst_ready SHALL remove the head entry at the clock edge.
REQ-018 inst_valid SHALL be 1 iff count!=0 (except REQ-029 bypass); inst/inst_pc SHALL be head entry, don't-care when invalid.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH.
REQ-020 Full (count=DEPTH) without pop: no push, fetch_pc SHALL hold.
REQ-021 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-022 Redirect cycle: a valid&ready handshake SHALL still complete; all remaining entries SHALL be discarded, no push, count->0, fetch_pc->redirect_pc next edge.
REQ-023 Cycle after redirect: imem_addr=redirect_pc; inst_valid=0 (no bypass) or per REQ-029.
REQ-024 redirect while count=0 and inst_ready=1 SHALL produce no handshake and no push.
REQ-025 redirect_pc SHALL be used unmodified; low two bits are not checked.
REQ-026 Steady state with inst_ready=1 SHALL deliver one instruction per cycle, sequential PCs.

Reset
REQ-027 reset=1 SHALL set fetch_pc=RESET_PC, count=0, head/tail pointers=0, inst_valid=0; reset overrides redirect and handshakes in the same cycle.
REQ-028 Reset asserted mid-operation SHALL discard all entries; first post-reset imem_addr=RESET_PC.

Configuration
REQ-029 Macro IFQ_BYPASS_EN defined: when count=0 and redirect=0, inst_valid=1, inst=imem_data, inst_pc=fetch_pc combinationally; if inst_ready=1 the instruction is consumed without entering the queue and fetch_pc+=4; if inst_ready=0 it is pushed normally.
REQ-030 IFQ_BYPASS_EN undefined: no combinational imem_data->inst path; minimum fetch-to-inst_valid latency one cycle.

Verification
REQ-031 Reset release, inst_ready=1, imem returns addr-dependent words -> inst_pc sequence 0,4,8,12 one per cycle (bypass: from cycle 0; else from cycle 1).
REQ-032 inst_ready=0 for 8 cycles after reset -> count saturates at 4, imem_addr holds 0x10, then ready=1 -> PCs 0,4,8,12,16 in order, no loss/duplication.
REQ-033 count=3, redirect=1 with redirect_pc=0x40 and inst_ready=1 -> head delivered, count=0 next cycle, imem_addr=0x40, next inst_pc=0x40.
REQ-034 Full queue with inst_ready=1 each cycle -> count stays 4, one pop and one push per cycle.
REQ-035 redirect_pc=2^64-4, ready=1 -> inst_pc 0xFFFF_FFFF_FFFF_FFFC then 0x0.
REQ-036 reset asserted while count=2 and redirect=1 -> next cycle count=0, inst_valid=0, imem_addr=RESET_PC.
